bridge_arbiter: RTL
===================

BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_WAIT, default 1, meaning bridge-drive cycles per transfer; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-low (reset==0 resets on clk rising edge).
REQ-004 SHALL have ports m0_req/m1_req  input  1  transfer request, held until ready.
REQ-005 SHALL have ports m0_we/m1_we  input  1  1=write, 0=read.
REQ-006 SHALL have ports m0_addr/m1_addr  input  32  byte address.
REQ-007 SHALL have ports m0_wdata/m1_wdata  input  32  write data.
REQ-008 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata/m1_rdata  output  32  read data, valid while ready=1.
REQ-010 SHALL have ports m0_err/m1_err  output  1  bridge exception, valid while ready=1.
REQ-011 SHALL have ports br_we, br_re  output  1  bridge write/read enables.
REQ-012 SHALL have ports br_addr, br_wdata  output  32  bridge address/write data.
REQ-013 SHALL have ports br_rdata  input  32 and br_exc  input  1  bridge response (combinational from br_*).

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; one transfer in flight at a time.
REQ-015 IDLE: if any req=1, SHALL grant one master, latch its we/addr/wdata, load wait counter with ACCESS_WAIT-1, go ACCESS; else stay IDLE.
REQ-016 Arbitration SHALL be round-robin: single requester wins; both requesting -> master other than last_grant wins; last_grant updates on each grant.
REQ-017 ACCESS: br_addr/br_wdata SHALL show latched values; br_re=~we for every ACCESS cycle; br_we=we only in the final ACCESS cycle (counter==0), so exactly one write strobe per write transfer.
REQ-018 ACCESS: counter SHALL decrement each cycle; at counter==0 SHALL register br_rdata and br_exc and go DONE.
REQ-019 On br_exc=1 captured: err=1, rdata=0; else err=0, rdata=captured br_rdata (writes also return br_rdata).
REQ-020 DONE: granted master's ready=1 for exactly one cycle with rdata/err; other master's ready=0; go IDLE unconditionally.
REQ-021 Latency: req seen in IDLE at cycle N -> ready at cycle N+ACCESS_WAIT+1; new requests are sampled only in IDLE (DONE cycle never grants).
REQ-022 Outside ACCESS: br_we=br_re=0; br_addr/br_wdata SHALL be 0.
REQ-023 req deasserted mid-transfer SHALL be ignored: transfer completes and ready still pulses.
REQ-024 rdata/err outputs SHALL be 0 whenever ready=0.
REQ-025 Changes to m*_addr/we/wdata after grant SHALL NOT affect the in-flight transfer.

Reset
REQ-026 reset==0 SHALL force state=IDLE, counter=0, last_grant=m1 (so m0 wins first tie), all outputs 0, captured data/err 0.
REQ-027 Reset during ACCESS before the final cycle SHALL suppress the pending br_we strobe; reset in DONE SHALL suppress ready.

Structure
REQ-028 State encoding and device window constants (TC0 0x7F00-0x7F0B, TC1 0x7F10-0x7F1B) SHALL reside in the shared constants file.
REQ-029 Round-robin choice SHALL be a sub-module rr_pick2 (inputs req0, req1, last; outputs gnt0, gnt1, combinational).
REQ-030 Target size 120-400 RTL lines; no memories, single clock domain.

Verification
REQ-031 ACCESS_WAIT=1, m0 read 0x7F04, bridge returns 0x1234 -> br_re high 1 cycle, m0_ready at N+2 with rdata=0x1234, err=0.
REQ-032 Both req from reset, m0 write 0x7F00 data 0x9, m1 read 0x7F14 -> m0 served first (single br_we pulse, wdata=0x9), then m1; alternation continues while both held.
REQ-033 ACCESS_WAIT=3, m1 write 0x7F10 -> br_we high only in 3rd ACCESS cycle, m1_ready at N+4.
REQ-034 m0 read 0x8000, br_exc=1, br_rdata=0xFFFF -> m0_ready with err=1, rdata=0.
REQ-035 ACCESS_WAIT=3, reset asserted in 2nd ACCESS cycle of a write -> no br_we pulse, no ready, all outputs 0 next cycle, next tie grants m0.
REQ-036 m0 drops req and changes addr after grant -> original address held on br_addr, m0_ready still pulses.

Source files
------------

// File: rtl/bridge_arbiter_pkg.sv
// Shared constants for the two-master bridge arbiter: FSM encoding,
// counter width and the timer/counter device address windows.
package bridge_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Wide enough for ACCESS_WAIT-1 with ACCESS_WAIT up to 15.
  localparam int CNT_W = 4;

  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC0_LAST = 32'h0000_7F0B;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TC1_LAST = 32'h0000_7F1B;

endpackage

// File: rtl/bridge_arbiter_rr_pick2.sv
// Two-way round-robin pick. 'last' = 1 means master 1 was granted last,
// so master 0 wins a tie.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/bridge_arbiter.sv
// Arbitrates two masters onto one bridge port, one transfer at a time,
// with registered bridge strobes and a one-cycle completion pulse.
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int ACCESS_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        br_we,
  output logic        br_re,
  output logic [31:0] br_addr,
  output logic [31:0] br_wdata,
  input  logic [31:0] br_rdata,
  input  logic        br_exc
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        cap_rdata_q, cap_rdata_d;
  logic               cap_err_q, cap_err_d;

  logic               br_we_q, br_we_d;
  logic               br_re_q, br_re_d;
  logic [31:0]        br_addr_q, br_addr_d;
  logic [31:0]        br_wdata_q, br_wdata_d;
  logic               m0_ready_q, m0_ready_d;
  logic [31:0]        m0_rdata_q, m0_rdata_d;
  logic               m0_err_q, m0_err_d;
  logic               m1_ready_q, m1_ready_d;
  logic [31:0]        m1_rdata_q, m1_rdata_d;
  logic               m1_err_q, m1_err_d;

  logic               gnt0, gnt1;
  logic               in_access, in_done;

  rr_pick2 u_pick (
    .req0 (m0_req),
    .req1 (m1_req),
    .last (last_q),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_rdata_d = cap_rdata_q;
    cap_err_d   = cap_err_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          last_d  = gnt1;
          we_d    = gnt1 ? m1_we    : m0_we;
          addr_d  = gnt1 ? m1_addr  : m0_addr;
          wdata_d = gnt1 ? m1_wdata : m0_wdata;
          cnt_d   = CNT_W'(ACCESS_WAIT - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          cap_rdata_d = br_exc ? 32'h0 : br_rdata;
          cap_err_d   = br_exc;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    in_access  = (state_d == ST_ACCESS);
    in_done    = (state_d == ST_DONE);
    br_re_d    = in_access & ~we_d;
    br_we_d    = in_access & we_d & (cnt_d == '0);
    br_addr_d  = in_access ? addr_d  : 32'h0;
    br_wdata_d = in_access ? wdata_d : 32'h0;
    m0_ready_d = in_done & ~owner_d;
    m1_ready_d = in_done &  owner_d;
    m0_rdata_d = m0_ready_d ? cap_rdata_d : 32'h0;
    m1_rdata_d = m1_ready_d ? cap_rdata_d : 32'h0;
    m0_err_d   = m0_ready_d & cap_err_d;
    m1_err_d   = m1_ready_d & cap_err_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cap_rdata_q <= 32'h0;
      cap_err_q   <= 1'b0;
      br_we_q     <= 1'b0;
      br_re_q     <= 1'b0;
      br_addr_q   <= 32'h0;
      br_wdata_q  <= 32'h0;
      m0_ready_q  <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m0_err_q    <= 1'b0;
      m1_ready_q  <= 1'b0;
      m1_rdata_q  <= 32'h0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_rdata_q <= cap_rdata_d;
      cap_err_q   <= cap_err_d;
      br_we_q     <= br_we_d;
      br_re_q     <= br_re_d;
      br_addr_q   <= br_addr_d;
      br_wdata_q  <= br_wdata_d;
      m0_ready_q  <= m0_ready_d;
      m0_rdata_q  <= m0_rdata_d;
      m0_err_q    <= m0_err_d;
      m1_ready_q  <= m1_ready_d;
      m1_rdata_q  <= m1_rdata_d;
      m1_err_q    <= m1_err_d;
    end
  end

  assign br_we    = br_we_q;
  assign br_re    = br_re_q;
  assign br_addr  = br_addr_q;
  assign br_wdata = br_wdata_q;
  assign m0_ready = m0_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_ready = m1_ready_q;
  assign m1_rdata = m1_rdata_q;
  assign m1_err   = m1_err_q;

endmodule
